// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: one requester's request/response channel to the
// BRAM port arbiter. The requester uses the master modport and the arbiter
// uses the slave modport.
interface bram_port_arbiter_if;
    logic        req;
    logic        ready;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, wdata, input  ready, rvalid, rdata, err);
    modport slave  (input  req, we, addr, wdata, output ready, rvalid, rdata, err);
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares data-memory BRAM port B between the load/store
// unit (m0) and the debug loader (m1) using round-robin arbitration. It also
// sequences a whole-memory clear through the BRAM rstb input.
// Optional feature: define BRAM_ARB_RANGE_CHK_EN to keep accesses with
// addr[31:2] >= MEM_DEPTH away from the BRAM and flag them with mX_err.
module bram_port_arbiter #(
    parameter int unsigned MEM_DEPTH = 1096,
    parameter bit          RR_INIT   = 1'b0
) (
    input  logic               clkb,
    input  logic               rstb_n,
    bram_port_arbiter_if.slave m0,
    bram_port_arbiter_if.slave m1,
    input  logic               clr_req,
    output logic               clr_done,
    output logic               busy,
    output logic               enb,
    output logic               rstb,
    output logic [3:0]         web,
    output logic [31:0]        addrb,
    output logic [31:0]        dinb,
    input  logic [31:0]        doutb,
    input  logic               rstb_busy
);

`ifdef BRAM_ARB_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ACCESS, RESP, CLEAR, CLR_WAIT} state_t;

    state_t      state_q, state_d;
    logic        rr_prio_q;          // requester that wins the next tie
    logic        owner_q;            // requester of the transaction in flight
    logic        oor_q;              // transaction in flight is out of range
    logic [31:0] hold0_q, hold1_q;   // last response data per requester

    logic        accept_pt, accept, grant, sel_oor;
    logic [3:0]  sel_we;
    logic [31:0] sel_addr, sel_wdata, resp_data;
    logic        rv0, rv1;

    // Arbitration, request selection and next-state decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the block can infer a latch.
        state_d   = state_q;
        accept_pt = (state_q == IDLE) || (state_q == RESP);
        grant     = (m0.req && m1.req) ? rr_prio_q : m1.req;
        accept    = accept_pt && !clr_req && (m0.req || m1.req);
        sel_we    = grant ? m1.we    : m0.we;
        sel_addr  = grant ? m1.addr  : m0.addr;
        sel_wdata = grant ? m1.wdata : m0.wdata;
        sel_oor   = RANGE_CHK && ({2'b00, sel_addr[31:2]} >= 32'(MEM_DEPTH));

        unique case (state_q)
            IDLE, RESP: begin
                if (clr_req)     state_d = CLEAR;
                else if (accept) state_d = ACCESS;
                else             state_d = IDLE;
            end
            ACCESS:   state_d = RESP;
            CLEAR:    state_d = CLR_WAIT;
            CLR_WAIT: if (!rstb_busy) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Requester handshake and response outputs, plus the status outputs.
    always_comb begin
        rv0       = (state_q == RESP) && !owner_q;
        rv1       = (state_q == RESP) &&  owner_q;
        resp_data = oor_q ? 32'd0 : doutb;
        m0.ready  = accept && !grant;
        m1.ready  = accept &&  grant;
        m0.rvalid = rv0;
        m1.rvalid = rv1;
        m0.rdata  = rv0 ? resp_data : hold0_q;
        m1.rdata  = rv1 ? resp_data : hold1_q;
        m0.err    = rv0 && oor_q;
        m1.err    = rv1 && oor_q;
        clr_done  = (state_q == CLR_WAIT) && !rstb_busy;
        busy      = (state_q != IDLE);
    end

    // State, round-robin pointer, captured request and registered BRAM drive.
    always_ff @(posedge clkb or negedge rstb_n) begin
        if (!rstb_n) begin
            // NOTE: the data registers are reset only because the outputs they feed must read 0 out of reset.
            state_q   <= IDLE;
            rr_prio_q <= RR_INIT;
            owner_q   <= 1'b0;
            oor_q     <= 1'b0;
            hold0_q   <= '0;
            hold1_q   <= '0;
            enb       <= 1'b0;
            rstb      <= 1'b0;
            web       <= '0;
            addrb     <= '0;
            dinb      <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here sample its pre-edge inputs.
            state_q <= state_d;
            rstb    <= (state_d == CLEAR);
            if (accept) begin
                owner_q   <= grant;
                oor_q     <= sel_oor;
                rr_prio_q <= !grant;
                enb       <= !sel_oor;
                web       <= sel_oor ? 4'b0000 : sel_we;
                addrb     <= sel_addr;
                dinb      <= sel_wdata;
            end else begin
                enb <= 1'b0;
                web <= 4'b0000;
            end
            if (rv0) hold0_q <= resp_data;
            if (rv1) hold1_q <= resp_data;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed bench for bram_port_arbiter with a
// behavioural BRAM (write-first, one-cycle read latency, 3-cycle clear busy)
// and a scoreboard of expected responses.
module tb_bram_port_arbiter;

`ifdef BRAM_ARB_RANGE_CHK_EN
    localparam int unsigned DEPTH     = 16;
    localparam bit          RANGE_CHK = 1'b1;
`else
    localparam int unsigned DEPTH     = 1096;
    localparam bit          RANGE_CHK = 1'b0;
`endif

    typedef struct {
        bit          owner;
        logic [31:0] data;
        bit          err;
        int          due;
    } exp_t;

    logic        clkb = 1'b0;
    logic        rstb_n;
    logic        clr_req;
    logic        clr_done, busy, enb, rstb, rstb_busy;
    logic [3:0]  web;
    logic [31:0] addrb, dinb, doutb;

    bram_port_arbiter_if m0_if ();
    bram_port_arbiter_if m1_if ();

    bram_port_arbiter #(.MEM_DEPTH(DEPTH), .RR_INIT(1'b0)) dut (
        .clkb(clkb), .rstb_n(rstb_n), .m0(m0_if), .m1(m1_if),
        .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
        .enb(enb), .rstb(rstb), .web(web), .addrb(addrb), .dinb(dinb),
        .doutb(doutb), .rstb_busy(rstb_busy)
    );

    always #5 clkb = ~clkb;

    // Behavioural BRAM: write-first, registered read data, 3-cycle clear busy.
    logic [31:0] bram [0:2047];
    int unsigned busy_cnt = 0;
    always @(posedge clkb) begin
        logic [31:0] w;
        if (rstb) begin
            for (int i = 0; i < 2048; i++) bram[i] <= '0;
            busy_cnt <= 3;
            doutb    <= '0;
        end else begin
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (enb) begin
                w = bram[addrb[12:2]];
                for (int b = 0; b < 4; b++) if (web[b]) w[b*8 +: 8] = dinb[b*8 +: 8];
                bram[addrb[12:2]] <= w;
                doutb <= w;
            end
        end
    end
    assign rstb_busy = (busy_cnt != 0);

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [1:0]  last_ready;
    exp_t        sb [$];
    bit          grant_log [$];
    int          acc_log [$];
    logic [31:0] ref_mem [0:2047];
    bit          acc_pending = 1'b0;
    int          acc_cyc;
    logic [3:0]  acc_we;
    logic [31:0] acc_addr, acc_wdata;
    bit          acc_oor;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] wd);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Per-cycle checks at the falling edge: handshake legality, BRAM drive,
    // responses against the scoreboard, and recording of accepted requests.
    task automatic monitor();
        logic [1:0]  rdy, rv;
        logic [3:0]  we;
        logic [31:0] addr, wdata, data;
        bit          port, oor;
        exp_t        e;
        rdy = {m1_if.ready, m0_if.ready};
        rv  = {m1_if.rvalid, m0_if.rvalid};
        last_ready = rdy;
        chk("two_readies", 32'(rdy == 2'b11), 0);
        chk("ready_without_req", 32'(rdy & ~{m1_if.req, m0_if.req}), 0);
        if (acc_pending && acc_cyc == cyc) begin
            acc_pending = 1'b0;
            chk("access_enb", 32'(enb), 32'(!acc_oor));
            chk("access_web", 32'(web), acc_oor ? 32'd0 : 32'(acc_we));
            chk("access_addrb", addrb, acc_addr);
            chk("access_dinb", dinb, acc_wdata);
        end else begin
            chk("idle_enb_web", 32'({enb, web}), 0);
        end
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rvalid_owner", 32'(rv), e.owner ? 32'd2 : 32'd1);
            chk("resp_rdata", e.owner ? m1_if.rdata : m0_if.rdata, e.data);
            chk("resp_err", 32'(e.owner ? m1_if.err : m0_if.err), 32'(e.err));
        end else begin
            chk("rvalid_unexpected", 32'(rv), 0);
        end
        if (rdy != 2'b00) begin
            port  = rdy[1];
            we    = port ? m1_if.we    : m0_if.we;
            addr  = port ? m1_if.addr  : m0_if.addr;
            wdata = port ? m1_if.wdata : m0_if.wdata;
            oor   = RANGE_CHK && (addr[31:2] >= 30'(DEPTH));
            if (oor) data = '0;
            else begin
                data = merge(ref_mem[addr[12:2]], we, wdata);
                ref_mem[addr[12:2]] = data;
            end
            acc_pending = 1'b1;
            acc_cyc     = cyc + 1;
            acc_we      = we;
            acc_addr    = addr;
            acc_wdata   = wdata;
            acc_oor     = oor;
            e.owner = port; e.data = data; e.err = oor; e.due = cyc + 2;
            sb.push_back(e);
            grant_log.push_back(port);
            acc_log.push_back(cyc);
        end
    endtask

    // One clock cycle: check mid-cycle, then return 1 time unit after the edge.
    task automatic step();
        @(negedge clkb);
        monitor();
        @(posedge clkb);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit port, input logic req, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
        end else begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
        end
    endtask

    task automatic issue(input bit port, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int waits);
        drive(port, 1'b1, we, addr, wdata);
        waits = 0;
        do begin
            step();
            waits++;
        end while (!last_ready[port] && waits < 20);
        chk("accept_timeout", 32'(last_ready[port]), 1);
        drive(port, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || acc_pending) && n < 20) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 0);
    endtask

    task automatic xfer(input bit port, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        int w;
        issue(port, we, addr, wdata, w);
        drain();
    endtask

    // Both requesters hold reads until n accepts; checks alternation and spacing.
    task automatic contend(input int n, input bit first);
        int base = grant_log.size();
        int k = 0;
        drive(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 4'h0, 32'h20, 32'h0);
        while (grant_log.size() < base + n && k < 60) begin
            step();
            k++;
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("contend_count", 32'(grant_log.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk("grant_order", 32'(grant_log[base+i]), 32'(first ^ i[0]));
            if (i > 0) chk("accept_spacing", 32'(acc_log[base+i] - acc_log[base+i-1]), 2);
        end
        drain();
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_bram_ctl"}, 32'({enb, rstb, web}), 0);
        chk({pfx, "_addrb"}, addrb, 0);
        chk({pfx, "_dinb"}, dinb, 0);
        chk({pfx, "_flags"}, 32'({busy, clr_done, m0_if.ready, m1_if.ready,
                                  m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err}), 0);
        chk({pfx, "_rdata0"}, m0_if.rdata, 0);
        chk({pfx, "_rdata1"}, m1_if.rdata, 0);
    endtask

    initial begin
        int w;
        int n;
        rstb_n  = 1'b1;
        clr_req = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        #2 rstb_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clkb);
        #1 rstb_n = 1'b1;
        step();

        // Loader preloads memory with full-word writes.
        xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        xfer(1'b1, 4'hF, 32'h20, 32'h11223344);
        xfer(1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
        xfer(1'b1, 4'hF, 32'h3C, 32'h13579BDF);

`ifdef BRAM_ARB_RANGE_CHK_EN
        // First word past the end is blocked and flagged; last word succeeds.
        xfer(1'b0, 4'h0, 32'h40, 32'h0);
        xfer(1'b0, 4'h0, 32'h3C, 32'h0);
        chk("range_last_word_hold", m0_if.rdata, 32'h13579BDF);
`endif

        // Single read: accepted in the first cycle, data two cycles later.
        issue(1'b0, 4'h0, 32'h10, 32'h0, w);
        chk("single_read_latency", 32'(w), 1);
        drain();
        chk("single_read_hold", m0_if.rdata, 32'hDEADBEEF);
        step();
        chk("rdata_holds_idle", m0_if.rdata, 32'hDEADBEEF);

        // Byte write returns the merged word; a read-back agrees.
        xfer(1'b1, 4'b0010, 32'h20, 32'h0000AB00);
        chk("byte_write_merged", m1_if.rdata, 32'h1122AB44);
        xfer(1'b1, 4'h0, 32'h20, 32'h0);
        chk("byte_write_readback", m1_if.rdata, 32'h1122AB44);

        // Contention: m1 was granted last, so m0 leads.
        contend(6, 1'b0);

        // Clear has priority over both requesters.
        clr_req = 1'b1;
        drive(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 4'h0, 32'h20, 32'h0);
        step();
        chk("clr_priority_ready", 32'(last_ready), 0);
        clr_req = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("clear_rstb_busy", 32'({rstb, busy}), 32'b11);
        step();
        chk("clear_rstb_one_cycle", 32'(rstb), 0);
        n = 0;
        while (!clr_done && n < 20) begin
            step();
            n++;
        end
        chk("clr_wait_cycles", 32'(n), 3);
        chk("clr_done_busy", 32'({clr_done, busy}), 32'b11);
        step();
        chk("clr_done_pulse", 32'({clr_done, busy}), 0);
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        xfer(1'b0, 4'h0, 32'h10, 32'h0);
        chk("read_after_clear", m0_if.rdata, 32'h0);
        xfer(1'b1, 4'hF, 32'h20, 32'hA5A55A5A);

        // Reset during ACCESS drops the transaction.
        issue(1'b0, 4'h0, 32'h20, 32'h0, w);
        chk("pre_reset_access", 32'(enb), 1);
        rstb_n = 1'b0;
        #1 check_all_zero("mid_reset");
        sb.delete();
        acc_pending = 1'b0;
        step();
        step();
        rstb_n = 1'b1;
        repeat (3) step();

        // First tie after reset goes to RR_INIT (m0).
        contend(2, 1'b0);
        chk("post_reset_read", m1_if.rdata, 32'hA5A55A5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
